// File: rtl/lp_pkg.sv
// Shared definitions for the logic-probe capture path: reader FSM states,
// default frame sync byte and frame header length.
package lp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } rd_state_e;

    localparam logic [7:0]  LP_SYNC_BYTE = 8'hA5;
    localparam int unsigned LP_HDR_LEN   = 3;

endpackage

// File: rtl/capture_reader.sv
// Capture buffer readout engine. Walks the circular sample RAM oldest-first
// from the latched start address and streams SYNC, LEN_HI, LEN_LO and then
// every sample over a valid/ready byte interface. All outputs are registered.
module capture_reader
    import lp_pkg::*;
#(
    parameter int unsigned AW        = 10,
    parameter logic [7:0]  SYNC_BYTE = LP_SYNC_BYTE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] start_addr,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);

    // Sample count as a 17-bit value so AW=16 still yields LEN = 16'hFFFF.
    localparam logic [16:0] DEPTH_W   = 17'd1 << AW;
    localparam logic [15:0] FRAME_LEN = 16'(DEPTH_W - 17'd1);
    localparam logic [AW:0] IDX_END   = {1'b1, {AW{1'b0}}};
    localparam logic [1:0]  HDR_LAST  = 2'(LP_HDR_LEN - 1);

    rd_state_e     state_r, state_n_s;
    logic [AW-1:0] base_r, base_n_s;
    logic [AW:0]   idx_r, idx_n_s, idx_inc_s;
    logic [1:0]    hdr_r, hdr_n_s;
    logic [7:0]    tx_data_r, tx_data_n_s;
    logic          tx_valid_r, tx_valid_n_s;
    logic          mem_re_r, mem_re_n_s;
    logic [AW-1:0] mem_raddr_r, mem_raddr_n_s;
    logic          busy_r, busy_n_s;
    logic          done_r, done_n_s;
    logic          hs_s;

    // Header byte selected by position within the frame header.
    function automatic logic [7:0] hdr_byte(input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = SYNC_BYTE;
            2'd1:    b = FRAME_LEN[15:8];
            2'd2:    b = FRAME_LEN[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign hs_s      = tx_valid_r && tx_ready;
    assign idx_inc_s = idx_r + {{AW{1'b0}}, 1'b1};

    // Next-state and next-output computation; abort overrides everything.
    always_comb begin
        state_n_s     = state_r;
        base_n_s      = base_r;
        idx_n_s       = idx_r;
        hdr_n_s       = hdr_r;
        tx_data_n_s   = tx_data_r;
        tx_valid_n_s  = 1'b0;
        mem_re_n_s    = 1'b0;
        mem_raddr_n_s = mem_raddr_r;
        done_n_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_n_s    = ST_HDR;
                    base_n_s     = start_addr;
                    idx_n_s      = '0;
                    hdr_n_s      = 2'd0;
                    tx_data_n_s  = hdr_byte(2'd0);
                    tx_valid_n_s = 1'b1;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                tx_valid_n_s = 1'b1;
                if (hs_s) begin
                    if (hdr_r == HDR_LAST) begin
                        state_n_s     = ST_FETCH;
                        tx_valid_n_s  = 1'b0;
                        mem_re_n_s    = 1'b1;
                        mem_raddr_n_s = base_r + idx_r[AW-1:0];
                    end else begin
                        hdr_n_s     = hdr_r + 2'd1;
                        tx_data_n_s = hdr_byte(hdr_r + 2'd1);
                    end
                end else begin
                    state_n_s = ST_HDR;
                end
            end
            ST_FETCH: begin
                state_n_s = ST_LOAD;
            end
            ST_LOAD: begin
                // RAM data is valid exactly one cycle after the FETCH read.
                state_n_s    = ST_SEND;
                tx_data_n_s  = mem_rdata;
                tx_valid_n_s = 1'b1;
            end
            ST_SEND: begin
                tx_valid_n_s = 1'b1;
                if (hs_s) begin
                    idx_n_s      = idx_inc_s;
                    tx_valid_n_s = 1'b0;
                    if (idx_inc_s == IDX_END) begin
                        state_n_s = ST_DONE;
                        done_n_s  = 1'b1;
                    end else begin
                        state_n_s     = ST_FETCH;
                        mem_re_n_s    = 1'b1;
                        mem_raddr_n_s = base_r + idx_inc_s[AW-1:0];
                    end
                end else begin
                    state_n_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase

        // Abort discards any handshake of this cycle and returns to idle.
        if (abort && (state_r != ST_IDLE)) begin
            state_n_s     = ST_IDLE;
            idx_n_s       = idx_r;
            hdr_n_s       = hdr_r;
            tx_data_n_s   = tx_data_r;
            tx_valid_n_s  = 1'b0;
            mem_re_n_s    = 1'b0;
            mem_raddr_n_s = mem_raddr_r;
            done_n_s      = 1'b0;
        end else begin
            state_n_s = state_n_s;
        end

        busy_n_s = (state_n_s != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            base_r      <= '0;
            idx_r       <= '0;
            hdr_r       <= 2'd0;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_raddr_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            base_r      <= base_n_s;
            idx_r       <= idx_n_s;
            hdr_r       <= hdr_n_s;
            tx_data_r   <= tx_data_n_s;
            tx_valid_r  <= tx_valid_n_s;
            mem_re_r    <= mem_re_n_s;
            mem_raddr_r <= mem_raddr_n_s;
            busy_r      <= busy_n_s;
            done_r      <= done_n_s;
        end
    end

    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign mem_re    = mem_re_r;
    assign mem_raddr = mem_raddr_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_capture_reader.sv
// Directed bench for capture_reader with AW=4 (16 samples, 19-byte frames).
module tb_capture_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] start_addr;
    logic       mem_re;
    logic [3:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;

    logic [7:0] ram [16];
    int         errors;
    int         checks;
    int         frames;
    int         nb;
    bit         hit;
    bit         dn;

    capture_reader #(.AW(4), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .mem_re     (mem_re),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_raddr];
    end

    // Completed-frame counter
    always @(posedge clk) begin
        if (done) frames <= frames + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_ram(input logic [7:0] key);
        for (int i = 0; i < 16; i++) ram[i] = 8'(i) ^ key;
    endtask

    // One complete frame: request it, consume bytes, check order and timing.
    task automatic run_frame(input logic [3:0] addr, input bit rnd, input int poke, input bit chk_len);
        int         b;
        int         nfetch;
        int         cyc;
        logic [7:0] exp_b;
        logic [3:0] a;
        bit         stall;
        logic [7:0] held;
        bit         seen;
        b = 0; nfetch = 0; cyc = 0; stall = 1'b0; held = 8'h00; seen = 1'b0;
        start_addr = addr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (c == poke) begin
                start = 1'b1;
                start_addr = 4'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                cyc = c;
                seen = 1'b1;
                break;
            end
            if (stall && tx_valid) chk("hold", {24'd0, tx_data}, {24'd0, held});
            if (mem_re) begin
                a = addr + 4'(nfetch);
                chk("raddr", {28'd0, mem_raddr}, {28'd0, a});
                nfetch++;
            end
            tx_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (tx_valid && tx_ready) begin
                case (b)
                    0:       exp_b = 8'hA5;
                    1:       exp_b = 8'h00;
                    2:       exp_b = 8'h0F;
                    default: begin
                        a = addr + 4'(b - 3);
                        exp_b = ram[a];
                    end
                endcase
                chk("byte", {24'd0, tx_data}, {24'd0, exp_b});
                b++;
            end
            stall = tx_valid && !tx_ready;
            held = tx_data;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("nbytes", b, 32'd19);
        if (chk_len) chk("latency", cyc, 32'd52);
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        errors = 0; checks = 0; frames = 0;
        rst = 1'b0; start = 1'b0; abort = 1'b0; start_addr = 4'd0;
        tx_ready = 1'b1; mem_rdata = 8'h00;
        fill_ram(8'h00);

        // Reset state
        #12;
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_re", {31'd0, mem_re}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_raddr", {28'd0, mem_raddr}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Plain frame from address 0, RAM[i]=i
        run_frame(4'd0, 1'b0, 0, 1'b1);
        // Wrapping frame from address 13 with distinct contents
        fill_ram(8'h5A);
        run_frame(4'd13, 1'b0, 0, 1'b1);
        // Random back-pressure, plus a start pulse while busy
        run_frame(4'd13, 1'b1, 10, 1'b0);
        chk("frames3", frames, 32'd3);

        // start and abort together in idle: ignored
        start = 1'b1; abort = 1'b1; start_addr = 4'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", {31'd0, busy}, 32'd0);
        chk("sa_valid", {31'd0, tx_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("sa_busy2", {31'd0, busy}, 32'd0);
        chk("frames_sa", frames, 32'd3);

        // Abort during the fifth sample's SEND
        tx_ready = 1'b1;
        start_addr = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nb = 0; hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (tx_valid && nb == 7) begin
                abort = 1'b1;
                hit = 1'b1;
                break;
            end
            if (tx_valid) nb++;
            @(posedge clk); #1;
        end
        chk("abort_reached", {31'd0, hit}, 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_valid", {31'd0, tx_valid}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_re", {31'd0, mem_re}, 32'd0);
        dn = done;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            dn = dn | done;
        end
        chk("ab_nodone", {31'd0, dn}, 32'd0);
        chk("frames_ab", frames, 32'd3);
        run_frame(4'd7, 1'b0, 0, 1'b1);
        chk("frames4", frames, 32'd4);

        // Asynchronous reset between clock edges, mid-frame
        start_addr = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_valid", {31'd0, tx_valid}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_re", {31'd0, mem_re}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        chk("ar_data", {24'd0, tx_data}, 32'd0);
        chk("ar_raddr", {28'd0, mem_raddr}, 32'd0);
        #13;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ar_idle_busy", {31'd0, busy}, 32'd0);
        chk("ar_idle_valid", {31'd0, tx_valid}, 32'd0);
        run_frame(4'd9, 1'b0, 0, 1'b1);
        chk("frames5", frames, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/capture_reader.md
# capture_reader

Readout engine for the logic-probe capture buffer: the read-side counterpart of the sampler that fills the circular 8-bit sample RAM. After a capture completes, it walks the RAM oldest-sample-first from a given start address and streams a framed byte sequence (sync, length, samples) over a valid/ready byte interface toward the host link (UART TX).

## Interface
Parameters:
- AW, 10, RAM address width; DEPTH = 2^AW samples; legal range 2..16
- SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to dump the buffer; honoured only when idle
- abort  in  1  terminate a dump in progress
- start_addr  in  AW  address of the oldest sample (sampler's final write pointer); latched on accepted start
- mem_re  out  1  RAM read enable
- mem_raddr  out  AW  RAM read address
- mem_rdata  in  8  RAM read data, valid exactly one cycle after mem_re
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last frame byte is accepted

## Operation
- Reset values: all outputs 0, state IDLE, sample index 0.
- Frame:
  - SYNC_BYTE
  - LEN_HI, LEN_LO: the 16-bit value DEPTH-1, zero-extended; for AW=16 this is 16'hFFFF
  - then DEPTH samples
- FSM states: IDLE, HDR, FETCH, LOAD, SEND, DONE.
- IDLE:
  - on start && !abort, latch start_addr into base, clear idx (AW+1 bits), clear hdr_cnt, go to HDR
  - start in any other state is ignored
- HDR:
  - tx_valid=1 and tx_data = header byte selected by hdr_cnt (0,1,2)
  - on handshake, increment hdr_cnt
  - after the third handshake, go to FETCH
- FETCH:
  - mem_re=1, mem_raddr = base + idx[AW-1:0] (mod DEPTH; natural wrap)
  - go to LOAD
- LOAD:
  - register mem_rdata into tx_data, set tx_valid
  - go to SEND
- SEND:
  - hold tx_data and tx_valid until handshake
  - on handshake, increment idx
  - if the new idx == DEPTH, go to DONE; else go to FETCH
- DONE:
  - done=1 for this single cycle, tx_valid=0
  - go to IDLE
- abort:
  - in any non-IDLE state, go to IDLE next cycle; tx_valid and mem_re drop; done not pulsed
  - a handshake in the abort cycle is not counted
  - abort beats a same-cycle start
- tx_data is stable while tx_valid is high and no handshake has occurred, except on abort.
- mem_re is high only in FETCH; mem_raddr holds its last value otherwise.

## Timing
- start accepted at edge N: HDR from N+1, tx_valid=SYNC_BYTE visible in cycle N+1.
- With tx_ready tied high:
  - header bytes take 1 cycle each
  - each sample takes 3 cycles (FETCH, LOAD, SEND)
  - total from start edge to done pulse: 3 + 3·DEPTH + 1 cycles
- RAM read latency is fixed at 1; LOAD samples mem_rdata exactly one cycle after FETCH.
- Back-pressure stalls only SEND/HDR; no bytes lost or duplicated.
- Async reset mid-frame: immediate return to IDLE, outputs 0; no partial resumption.
- busy rises the cycle after an accepted start and falls the cycle after DONE.

## Structure
- Shared package `lp_pkg`:
  - state enum / localparams for reader states
  - SYNC_BYTE default
  - frame header length constant (3)
- Single module, no sub-module. The header byte mux may be a local function.

## Test plan
- AW=4, start_addr=4'd0, RAM[i]=i, tx_ready=1 → bytes A5,00,0F,00..0F; done one cycle, 52 cycles after start.
- AW=4, start_addr=4'd13 → samples RAM[13],RAM[14],RAM[15],RAM[0]..RAM[12]; address wraps 15→0.
- Random tx_ready (~30% high) → identical byte sequence to the ready=1 case; tx_data never changes while valid && !ready.
- abort asserted during the 5th sample SEND → tx_valid low next cycle, busy low, no done; a subsequent start produces a full frame from SYNC.
- start pulsed while busy, and start+abort in the same IDLE cycle → both ignored; frame count unchanged.
- rst asserted asynchronously mid-frame (between clock edges) → all outputs 0 immediately; after release, IDLE with busy=0.
